dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 3, meaning the maximum consecutive cycles a pending VGA beat may lose to the CPU.
REQ-002 SHALL have parameter ADDR_W, default 12, meaning the dmem word-address width.
REQ-003 SHALL have parameter DATA_W, default 32, meaning the dmem word width.
REQ-004 clock  in  1  single clock; all state updates on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 cpu_req  in  1  CPU access request, held until cpu_gnt.
REQ-007 cpu_we  in  1  CPU request is a write.
REQ-008 cpu_addr  in  ADDR_W  CPU word address.
REQ-009 cpu_wdata  in  DATA_W  CPU write data.
REQ-010 cpu_gnt  out  1  CPU access issued to dmem this cycle (combinational).
REQ-011 cpu_rvalid / cpu_rdata  out  1 / DATA_W  CPU read-return strobe and data.
REQ-012 vga_req  in  1  start a VGA burst read (single-cycle pulse accepted only when idle).
REQ-013 vga_base / vga_len  in  ADDR_W / 4  burst start address; beat count = vga_len+1 (1..16).
REQ-014 vga_busy  out  1  burst in progress (states BURST or DRAIN).
REQ-015 vga_rvalid / vga_rdata / vga_beat  out  1 / DATA_W / 4  VGA read-return strobe, data, beat index.
REQ-016 vga_done  out  1  one-cycle pulse coincident with last beat's vga_rvalid.
REQ-017 mem_address / mem_data / mem_wren  out  ADDR_W / DATA_W / 1  to dmem port (combinational mux).
REQ-018 mem_q  in  DATA_W  dmem read data, valid one cycle after address presented.

Function
REQ-019 VGA FSM SHALL have states IDLE, BURST, DRAIN.
REQ-020 IDLE: on vga_req=1 SHALL latch vga_base, vga_len, clear beat index, enter BURST next cycle; vga_req ignored in BURST/DRAIN.
REQ-021 In IDLE and DRAIN, cpu_gnt SHALL equal cpu_req.
REQ-022 In BURST a VGA beat SHALL issue when cpu_req=0 or starve_cnt==STARVE_LIMIT; otherwise CPU is granted.
REQ-023 starve_cnt SHALL increment each BURST cycle the CPU wins, clear to 0 on any VGA beat issue, and clear on exit from BURST.
REQ-024 cpu_gnt SHALL be 0 in any cycle a VGA beat issues.
REQ-025 VGA beat k SHALL drive mem_address = (base + k) mod 2^ADDR_W (wrap at 0xFFF to 0x000), mem_wren=0.
REQ-026 CPU grant SHALL drive mem_address=cpu_addr, mem_data=cpu_wdata, mem_wren=cpu_we.
REQ-027 No grant: mem_address=0, mem_data=0, mem_wren=0.
REQ-028 After issuing beat len, FSM SHALL enter DRAIN for exactly one cycle, then IDLE.
REQ-029 Read latency: one cycle after a CPU read grant, cpu_rvalid=1 and cpu_rdata=mem_q; writes produce no rvalid.
REQ-030 One cycle after VGA beat k issue, vga_rvalid=1, vga_beat=k, vga_rdata=mem_q; vga_done=1 when k==len.
REQ-031 cpu_rdata/vga_rdata SHALL be 0 when respective rvalid=0.
REQ-032 Accesses SHALL be strictly serialized in grant order; a CPU write granted before a VGA beat to the same address is visible to that beat.

Reset
REQ-033 On reset: FSM=IDLE, starve_cnt=0, beat index=0, pending-return flags cleared; next cycle all outputs 0.
REQ-034 Reset mid-burst SHALL abort the burst: no vga_rvalid or vga_done for the in-flight beat.

Verification
REQ-035 Write 0xDEADBEEF to 0x010, then read 0x010 -> cpu_gnt both cycles, mem_wren=1 then 0, cpu_rvalid one cycle after read with 0xDEADBEEF.
REQ-036 vga_req base 0x100 len 3, cpu idle -> addresses 0x100..0x103 on 4 consecutive cycles, vga_rvalid beats 0..3 one cycle later, vga_done with beat 3, vga_busy low next cycle.
REQ-037 cpu_req held high, burst len 1, STARVE_LIMIT=3 -> pattern cpu,cpu,cpu,vga,cpu,cpu,cpu,vga, then DRAIN, cpu continuous.
REQ-038 base 0xFFE len 3 -> addresses 0xFFE, 0xFFF, 0x000, 0x001.
REQ-039 reset asserted on cycle beat 2 issues -> next cycle vga_busy=0, vga_rvalid=0, vga_done=0, mem_wren=0.
REQ-040 vga_req pulsed with base 0x200 during active burst -> ignored; no 0x200 address appears, original burst completes unchanged.

Source files
------------

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - shares a single-port dmem between CPU accesses and VGA burst reads
// The VGA burst yields to the CPU, but never more than STARVE_LIMIT times in a row.
module dmem_arbiter #(
  parameter int STARVE_LIMIT = 3,
  parameter int ADDR_W       = 12,
  parameter int DATA_W       = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_base,
  input  logic [3:0]        vga_len,
  output logic              vga_busy,
  output logic              vga_rvalid,
  output logic [DATA_W-1:0] vga_rdata,
  output logic [3:0]        vga_beat,
  output logic              vga_done,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_q
);

  localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {IDLE, BURST, DRAIN} state_t;

  state_t            state;
  logic [ADDR_W-1:0] base_q;
  logic [3:0]        len_q;
  logic [3:0]        beat_q;
  logic [SW-1:0]     starve_cnt;
  logic              cpu_pend;
  logic              vga_pend;
  logic              vga_last_q;
  logic [3:0]        vga_beat_q;
  logic              vga_issue;
  logic [ADDR_W-1:0] vga_addr;

  assign vga_issue = (state == BURST) && (!cpu_req || (starve_cnt == SW'(STARVE_LIMIT)));
  assign cpu_gnt   = cpu_req && !vga_issue;
  assign vga_addr  = base_q + ADDR_W'(beat_q);

  always_comb begin
    mem_address = '0;
    mem_data    = '0;
    mem_wren    = 1'b0;
    if (vga_issue) begin
      mem_address = vga_addr;
    end else if (cpu_gnt) begin
      mem_address = cpu_addr;
      mem_data    = cpu_wdata;
      mem_wren    = cpu_we;
    end
  end

  // Return tags follow the one-cycle dmem read latency; reset drops any in-flight beat.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      base_q     <= '0;
      len_q      <= '0;
      beat_q     <= '0;
      starve_cnt <= '0;
      cpu_pend   <= 1'b0;
      vga_pend   <= 1'b0;
      vga_last_q <= 1'b0;
      vga_beat_q <= '0;
    end else begin
      cpu_pend   <= cpu_gnt && !cpu_we;
      vga_pend   <= vga_issue;
      vga_beat_q <= beat_q;
      vga_last_q <= (beat_q == len_q);
      case (state)
        IDLE: begin
          if (vga_req) begin
            base_q     <= vga_base;
            len_q      <= vga_len;
            beat_q     <= '0;
            starve_cnt <= '0;
            state      <= BURST;
          end
        end
        BURST: begin
          if (vga_issue) begin
            starve_cnt <= '0;
            if (beat_q == len_q) state <= DRAIN;
            else beat_q <= beat_q + 4'd1;
          end else begin
            starve_cnt <= starve_cnt + 1'b1;
          end
        end
        DRAIN: begin
          state      <= IDLE;
          beat_q     <= '0;
          starve_cnt <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign vga_busy   = (state != IDLE);
  assign cpu_rvalid = cpu_pend;
  assign cpu_rdata  = cpu_pend ? mem_q : '0;
  assign vga_rvalid = vga_pend;
  assign vga_rdata  = vga_pend ? mem_q : '0;
  assign vga_beat   = vga_pend ? vga_beat_q : 4'd0;
  assign vga_done   = vga_pend && vga_last_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter
module tb_dmem_arbiter;
  localparam int AW  = 12;
  localparam int DW  = 32;
  localparam int LIM = 3;

  logic          clock = 1'b0;
  logic          reset, cpu_req, cpu_we, vga_req;
  logic [AW-1:0] cpu_addr, vga_base, mem_address;
  logic [DW-1:0] cpu_wdata, cpu_rdata, vga_rdata, mem_data, mem_q;
  logic [3:0]    vga_len, vga_beat;
  logic          cpu_gnt, cpu_rvalid, vga_busy, vga_rvalid, vga_done, mem_wren;

  always #5 clock = ~clock;

  dmem_arbiter #(.STARVE_LIMIT(LIM), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clock(clock), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .vga_req(vga_req), .vga_base(vga_base), .vga_len(vga_len), .vga_busy(vga_busy),
    .vga_rvalid(vga_rvalid), .vga_rdata(vga_rdata), .vga_beat(vga_beat), .vga_done(vga_done),
    .mem_address(mem_address), .mem_data(mem_data), .mem_wren(mem_wren), .mem_q(mem_q)
  );

  logic [DW-1:0] dmem [0:4095];
  always @(posedge clock) begin
    if (mem_wren) dmem[mem_address] <= mem_data;
    mem_q <= dmem[mem_address];
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: pending VGA accesses are a queue of {addr,beat,last}; memory is a sparse map.
  typedef struct {logic [AW-1:0] addr; int beat; bit last;} beat_t;
  beat_t vq[$];
  int losses;
  bit drain;
  logic [DW-1:0] sm [int];
  bit p_cv, p_ck, p_vv, p_vk, p_vdone;
  logic [DW-1:0] p_cd, p_vd;
  int p_vb;

  task automatic model_reset();
    vq.delete();
    losses = 0; drain = 0;
    p_cv = 0; p_ck = 0; p_vv = 0; p_vk = 0; p_vdone = 0; p_vb = 0; p_cd = 0; p_vd = 0;
  endtask

  task automatic model_step(input bit rst);
    bit idle, issue, gnt, ew;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    beat_t hd;
    if (rst) begin
      model_reset();
      return;
    end
    idle  = (vq.size() == 0) && !drain;
    issue = (vq.size() != 0) && (!cpu_req || losses == LIM);
    gnt   = cpu_req && !issue;
    ea = '0; ed = '0; ew = 1'b0;
    if (issue) ea = vq[0].addr;
    else if (gnt) begin ea = cpu_addr; ed = cpu_wdata; ew = cpu_we; end
    check("cpu_gnt", cpu_gnt, gnt);
    check("mem_address", mem_address, ea);
    check("mem_data", mem_data, ed);
    check("mem_wren", mem_wren, ew);
    check("vga_busy", vga_busy, !idle);
    check("cpu_rvalid", cpu_rvalid, p_cv);
    if (!p_cv) check("cpu_rdata_zero", cpu_rdata, 0);
    else if (p_ck) check("cpu_rdata", cpu_rdata, p_cd);
    check("vga_rvalid", vga_rvalid, p_vv);
    check("vga_beat", vga_beat, p_vv ? p_vb : 0);
    check("vga_done", vga_done, p_vv && p_vdone);
    if (!p_vv) check("vga_rdata_zero", vga_rdata, 0);
    else if (p_vk) check("vga_rdata", vga_rdata, p_vd);

    p_cv = gnt && !cpu_we;
    p_ck = p_cv && sm.exists(int'(cpu_addr));
    if (p_ck) p_cd = sm[int'(cpu_addr)];
    if (gnt && cpu_we) sm[int'(cpu_addr)] = cpu_wdata;
    p_vv = issue; p_vk = 0; p_vdone = 0; p_vb = 0;
    if (issue) begin
      hd = vq.pop_front();
      p_vb = hd.beat;
      p_vdone = hd.last;
      p_vk = sm.exists(int'(hd.addr));
      if (p_vk) p_vd = sm[int'(hd.addr)];
      losses = 0;
    end else if (vq.size() != 0 && gnt) begin
      losses++;
    end
    drain = p_vdone;
    if (idle && vga_req)
      for (int k = 0; k <= int'(vga_len); k++)
        vq.push_back('{addr: AW'(int'(vga_base) + k), beat: k, last: (k == int'(vga_len))});
  endtask

  logic          s_gnt, s_wren, s_busy, s_cv, s_vrv, s_done;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_data, s_crd, s_vrd;
  logic [3:0]    s_beat;

  task automatic cycle(input bit rq, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                       input bit vr, input logic [AW-1:0] vb, input logic [3:0] vl, input bit rst);
    cpu_req = rq; cpu_we = we; cpu_addr = a; cpu_wdata = wd;
    vga_req = vr; vga_base = vb; vga_len = vl; reset = rst;
    @(negedge clock);
    s_gnt = cpu_gnt; s_addr = mem_address; s_data = mem_data; s_wren = mem_wren;
    s_busy = vga_busy; s_cv = cpu_rvalid; s_crd = cpu_rdata; s_vrv = vga_rvalid;
    s_vrd = vga_rdata; s_beat = vga_beat; s_done = vga_done;
    model_step(rst);
    @(posedge clock);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) cycle(0, 0, '0, '0, 0, '0, 4'd0, 0);
  endtask

  function automatic logic [AW-1:0] pick_addr();
    if ($urandom_range(0, 3) == 0) return AW'(12'hFF8 + $urandom_range(0, 7));
    return AW'($urandom_range(0, 31));
  endfunction

  typedef struct {
    bit req; bit we; logic [AW-1:0] addr; logic [DW-1:0] wdata;
    bit e_gnt; logic [AW-1:0] e_addr; logic [DW-1:0] e_data; bit e_wren; bit e_rv; logic [DW-1:0] e_rd;
  } vec_t;
  vec_t tv [8];
  bit exp37 [8];

  initial begin
    logic cr, cw, vr;
    logic [AW-1:0] ca, vb;
    logic [DW-1:0] cd;
    logic [3:0] vl;

    tv[0] = '{1, 1, 12'h010, 32'hDEADBEEF, 1, 12'h010, 32'hDEADBEEF, 1, 0, 32'h0};
    tv[1] = '{1, 0, 12'h010, 32'h0,        1, 12'h010, 32'h0,        0, 0, 32'h0};
    tv[2] = '{0, 0, 12'h000, 32'h0,        0, 12'h000, 32'h0,        0, 1, 32'hDEADBEEF};
    tv[3] = '{1, 1, 12'hFFF, 32'h0BADF00D, 1, 12'hFFF, 32'h0BADF00D, 1, 0, 32'h0};
    tv[4] = '{1, 0, 12'hFFF, 32'h00000055, 1, 12'hFFF, 32'h00000055, 0, 0, 32'h0};
    tv[5] = '{1, 0, 12'h010, 32'h0,        1, 12'h010, 32'h0,        0, 1, 32'h0BADF00D};
    tv[6] = '{0, 1, 12'h123, 32'hFFFFFFFF, 0, 12'h000, 32'h0,        0, 1, 32'hDEADBEEF};
    tv[7] = '{0, 0, 12'h000, 32'h0,        0, 12'h000, 32'h0,        0, 0, 32'h0};
    exp37 = '{1, 1, 1, 0, 1, 1, 1, 0};
    model_reset();

    cycle(0, 0, '0, '0, 0, '0, 4'd0, 1);
    cycle(0, 0, '0, '0, 0, '0, 4'd0, 1);
    cycle(0, 0, '0, '0, 0, '0, 4'd0, 0);
    check("rst_gnt", s_gnt, 0);
    check("rst_addr", s_addr, 0);
    check("rst_wren", s_wren, 0);
    check("rst_busy", s_busy, 0);
    check("rst_cpu_rvalid", s_cv, 0);
    check("rst_vga_rvalid", s_vrv, 0);
    check("rst_vga_done", s_done, 0);

    for (int i = 0; i < 8; i++) begin
      cycle(tv[i].req, tv[i].we, tv[i].addr, tv[i].wdata, 0, '0, 4'd0, 0);
      check("tv_gnt", s_gnt, tv[i].e_gnt);
      check("tv_addr", s_addr, tv[i].e_addr);
      check("tv_data", s_data, tv[i].e_data);
      check("tv_wren", s_wren, tv[i].e_wren);
      check("tv_rvalid", s_cv, tv[i].e_rv);
      check("tv_rdata", s_crd, tv[i].e_rd);
    end

    // Uncontested burst: four back-to-back beats, returns one cycle behind.
    cycle(0, 0, '0, '0, 1, 12'h100, 4'd3, 0);
    for (int i = 0; i < 5; i++) begin
      cycle(0, 0, '0, '0, 0, '0, 4'd0, 0);
      if (i < 4) check("b36_addr", s_addr, 12'h100 + i);
      if (i >= 1) check("b36_beat", {s_vrv, s_beat}, {1'b1, 4'(i - 1)});
      check("b36_done", s_done, i == 4);
    end
    cycle(0, 0, '0, '0, 0, '0, 4'd0, 0);
    check("b36_busy_after", s_busy, 0);

    // CPU pressure: VGA wins only after LIM consecutive losses.
    cycle(1, 0, 12'h005, '0, 1, 12'h300, 4'd1, 0);
    check("s37_start_gnt", s_gnt, 1);
    for (int i = 0; i < 8; i++) begin
      cycle(1, 0, 12'h005, '0, 0, '0, 4'd0, 0);
      check("s37_gnt", s_gnt, exp37[i]);
      if (i == 3) check("s37_addr0", s_addr, 12'h300);
      if (i == 7) check("s37_addr1", s_addr, 12'h301);
    end
    cycle(1, 0, 12'h005, '0, 0, '0, 4'd0, 0);
    check("s37_drain", {s_gnt, s_busy, s_done}, 3'b111);
    cycle(1, 0, 12'h005, '0, 0, '0, 4'd0, 0);
    check("s37_idle", {s_gnt, s_busy}, 2'b10);
    idle_cycles(2);

    cycle(0, 0, '0, '0, 1, 12'hFFE, 4'd3, 0);
    for (int i = 0; i < 4; i++) begin
      cycle(0, 0, '0, '0, 0, '0, 4'd0, 0);
      check("w38_addr", s_addr, AW'(12'hFFE + i));
    end
    idle_cycles(2);

    // A second request mid-burst must not disturb the running one.
    cycle(0, 0, '0, '0, 1, 12'h040, 4'd2, 0);
    cycle(0, 0, '0, '0, 1, 12'h200, 4'd0, 0);
    check("i40_addr0", s_addr, 12'h040);
    for (int i = 1; i < 3; i++) begin
      cycle(0, 0, '0, '0, i == 1, 12'h200, 4'd0, 0);
      check("i40_addr", s_addr, 12'h040 + i);
    end
    cycle(0, 0, '0, '0, 0, '0, 4'd0, 0);
    check("i40_done", {s_done, s_beat}, {1'b1, 4'd2});
    cycle(0, 0, '0, '0, 0, '0, 4'd0, 0);
    check("i40_idle", {s_busy, s_vrv, s_addr}, '0);

    cycle(0, 0, '0, '0, 1, 12'h080, 4'd5, 0);
    cycle(0, 0, '0, '0, 0, '0, 4'd0, 0);
    cycle(0, 0, '0, '0, 0, '0, 4'd0, 0);
    cycle(0, 0, '0, '0, 0, '0, 4'd0, 1);
    cycle(0, 0, '0, '0, 0, '0, 4'd0, 0);
    check("r39_busy", s_busy, 0);
    check("r39_rvalid", s_vrv, 0);
    check("r39_done", s_done, 0);
    check("r39_wren", s_wren, 0);
    idle_cycles(3);

    cr = 0; cw = 0; ca = '0; cd = '0;
    repeat (2000) begin
      if (!(cr && !s_gnt)) begin
        cr = ($urandom_range(0, 3) != 0);
        cw = 1'($urandom_range(0, 1));
        ca = pick_addr();
        cd = $urandom;
      end
      vr = ($urandom_range(0, 9) == 0);
      vb = pick_addr();
      vl = 4'($urandom_range(0, 15));
      cycle(cr, cw, ca, cd, vr, vb, vl, 0);
    end
    idle_cycles(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
